pcileech_tlps128_pkt_buffer: RTL and testbench
==============================================

// Module: pcileech_tlps128_pkt_buffer
// PURPOSE
//  Store-and-forward TLP packet buffer on clk_pcie. Accepts a non-backpressured 128-bit TLP stream
//  (bar/cfg response style, tvalid-only) and offers it to the TX sink mux as a sink-mux input.
//  has_data rises only once a complete packet (tlast seen) is stored, so the mux never stalls mid-TLP.
//  Read latency is 1 clk, as the mux requires. Overflowing packets are dropped whole and counted.
// PARAMETERS
//  DEPTH_LOG2  9   buffer depth = 2**DEPTH_LOG2 beats of {tuser[0],tlast,tkeepdw[3:0],tdata[127:0]}
//  DROP_CNT_W  16  width of drop counter (saturating)
// PORTS
//  clk_pcie       in   1    clock
//  rst            in   1    synchronous, active-high reset
//  in_tdata       in   128  input beat data
//  in_tkeepdw     in   4    input DW keep (0001/0011/0111/1111)
//  in_tlast       in   1    last beat of TLP
//  in_tuser       in   9    tuser[0]=first beat of TLP; [8:1] ignored
//  in_tvalid      in   1    beat valid; no backpressure
//  out_tdata      out  128  output beat data
//  out_tkeepdw    out  4    output DW keep
//  out_tlast      out  1    output last
//  out_tuser      out  9    {8'b0, first}
//  out_tvalid     out  1    beat transferred this cycle (valid == transfer)
//  out_tready     in   1    mux grant; permits read issue this cycle
//  out_has_data   out  1    >=1 complete packet available
//  drop_count     out  DROP_CNT_W  packets dropped since reset, saturates at all-ones
//  level          out  DEPTH_LOG2+1  beats stored incl. uncommitted
// BEHAVIOUR
//  Reset: reset rst, synchronous, active-high; clock clk_pcie. wr_ptr=commit_ptr=rd_ptr=0,
//   pkt_count=0, wstate=IDLE, out_tvalid=0, out_has_data=0, drop_count=0, level=0.
//   Reset mid-packet discards all stored/partial data; out_tvalid is 0 in the cycle after rst.
//  Pointers DEPTH_LOG2+1 bits, wrap modulo 2**(DEPTH_LOG2+1); free = 2**DEPTH_LOG2 - (wr_ptr - rd_ptr).
//  Write FSM (wstate):
//   IDLE : in_tvalid&&first: if free>0 write at wr_ptr, wr_ptr++; tlast ? commit : ->WRITE.
//          no space -> drop++ ; tlast ? stay : ->DROP. in_tvalid&&!first: ignored (orphan beat).
//   WRITE: in_tvalid&&!first: free>0 -> write; tlast -> commit, ->IDLE.
//          free==0 -> wr_ptr<=commit_ptr (rewind), drop++, tlast ? ->IDLE : ->DROP.
//          in_tvalid&&first (lost tlast): rewind partial, drop++, then handle beat as in IDLE.
//   DROP : discard beats until tlast (->IDLE); a first beat here is handled as in IDLE.
//   commit: commit_ptr<=wr_ptr+1, pkt_inc=1. Packets > 2**DEPTH_LOG2 beats always drop.
//  Read side: pkt_dec = out_tvalid&&out_tlast; pkt_count_next = pkt_count + pkt_inc - pkt_dec
//   (simultaneous inc/dec => unchanged). out_has_data = (pkt_count_next>0).
//   rd_en = out_tready && (pkt_count_next>0); rd_en at cycle t -> beat at rd_ptr on outputs at t+1
//   with out_tvalid=1, rd_ptr++. No rd_en -> out_tvalid=0 next cycle (outputs may hold stale data).
//   Never reads beyond commit_ptr (guaranteed by count rule; assert rd_ptr!=commit_ptr on rd_en).
//  Free space is released on read issue; reads and writes in the same cycle are both honoured.
//  drop_count increments once per dropped packet, saturating; level = wr_ptr - rd_ptr.
// STRUCTURE
//  pcileech_header.svh/package: beat struct {first,tlast,tkeepdw,tdata} (134 b), wstate enum
//   {IDLE,WRITE,DROP}.
//  One sub-module: pcileech_ram_sdp_1clk (simple dual-port RAM, 134 b x 2**DEPTH_LOG2, registered
//   read, 1-clk latency). Pointer/count/FSM logic in this module.
// TESTING
//  1 3-beat TLP (tkeepdw 1111,1111,0011), out_tready=1 -> has_data 1 clk after tlast beat; 3 out
//    beats back-to-back, identical data, out_tlast on 3rd, has_data 0 same cycle as out tlast.
//  2 Two 1-beat TLPs back-to-back, out_tready toggling 1/0 -> 2 packets out in order, no extra
//    or duplicated beat, out_tvalid only one clk after each tready=1 cycle with packets pending.
//  3 DEPTH_LOG2=3, out_tready=0, send 6-beat then 4-beat TLP -> 1st stored, 2nd dropped,
//    drop_count=1, level=6; then tready=1 -> only 6-beat TLP emitted.
//  4 First beat while WRITE (no tlast) -> partial rewound, drop_count+1, new TLP delivered intact.
//  5 rst asserted mid-output of a 4-beat TLP -> out_tvalid 0 next clk, has_data 0, level 0;
//    following TLP delivered normally.
//  6 Write commit and read of last tlast in same cycle -> pkt_count unchanged, has_data stays 1.

Source files
------------

// File: rtl/pcileech_tlps128_pkt_buffer_pkg.sv
// Shared types for the 128-bit TLP store-and-forward packet buffer.
package pcileech_tlps128_pkt_buffer_pkg;

  typedef struct packed {
    logic         first;
    logic         tlast;
    logic [3:0]   tkeepdw;
    logic [127:0] tdata;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wstate_t;

endpackage

// File: rtl/pcileech_tlps128_pkt_buffer_if.sv
// 128-bit TLP stream bundle; master drives the beat, slave returns tready.
// Handshake: a beat moves when tvalid is high; tready is a permit for the source to issue
// (the buffer output asserts tvalid only for beats it was permitted to issue the cycle before).
interface pcileech_tlps128_pkt_buffer_if;
  logic [127:0] tdata;
  logic [3:0]   tkeepdw;
  logic         tlast;
  logic [8:0]   tuser;
  logic         tvalid;
  logic         tready;
  logic         has_data;

  modport master (output tdata, tkeepdw, tlast, tuser, tvalid, has_data, input tready);
  modport slave  (input tdata, tkeepdw, tlast, tuser, tvalid, has_data, output tready);
endinterface

// File: rtl/pcileech_ram_sdp_1clk.sv
// Simple dual-port RAM, one clock, registered read with one cycle of latency.
module pcileech_ram_sdp_1clk #(
  parameter int AW = 9,
  parameter int DW = 134
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pcileech_tlps128_pkt_buffer.sv
// Store-and-forward TLP buffer: packets become visible only once fully stored;
// packets that do not fit are dropped whole and counted.
module pcileech_tlps128_pkt_buffer
  import pcileech_tlps128_pkt_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int DROP_CNT_W = 16
) (
  input  logic                          clk_pcie,
  input  logic                          rst,
  pcileech_tlps128_pkt_buffer_if.slave  in_bus,
  pcileech_tlps128_pkt_buffer_if.master out_bus,
  output logic [DROP_CNT_W-1:0]         drop_count,
  output logic [DEPTH_LOG2:0]           level,
  output wstate_t                       wstate
);
  localparam int PW = DEPTH_LOG2 + 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t ONE = ptr_t'(1);

  ptr_t wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr, waddr;
  ptr_t pkt_count, pkt_count_next;
  wstate_t wstate_n;
  logic we, pkt_inc, pkt_inc_q, pkt_dec, rd_en, out_valid;
  logic [1:0] drop_inc;
  logic [DROP_CNT_W:0] drop_sum;
  beat_t wbeat, rbeat;
  logic unused_bits;

  function automatic logic has_room(input ptr_t p, input ptr_t r);
    ptr_t used;
    used = p - r;
    return !used[PW-1];
  endfunction

  assign wbeat = {in_bus.tuser[0], in_bus.tlast, in_bus.tkeepdw, in_bus.tdata};

  always_comb begin
    wstate_n     = wstate;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    waddr        = wr_ptr;
    we           = 1'b0;
    pkt_inc      = 1'b0;
    drop_inc     = 2'd0;
    if (in_bus.tvalid) begin
      if (in_bus.tuser[0]) begin
        // A first beat always restarts at commit_ptr, which also rewinds a packet that lost its tlast.
        if (wstate == WRITE) drop_inc = 2'd1;
        wr_ptr_n = commit_ptr;
        waddr    = commit_ptr;
        if (has_room(commit_ptr, rd_ptr)) begin
          we       = 1'b1;
          wr_ptr_n = commit_ptr + ONE;
          if (in_bus.tlast) begin
            commit_ptr_n = commit_ptr + ONE;
            pkt_inc      = 1'b1;
            wstate_n     = IDLE;
          end else begin
            wstate_n = WRITE;
          end
        end else begin
          drop_inc = drop_inc + 2'd1;
          wstate_n = in_bus.tlast ? IDLE : DROP;
        end
      end else begin
        case (wstate)
          WRITE: begin
            if (has_room(wr_ptr, rd_ptr)) begin
              we       = 1'b1;
              wr_ptr_n = wr_ptr + ONE;
              if (in_bus.tlast) begin
                commit_ptr_n = wr_ptr + ONE;
                pkt_inc      = 1'b1;
                wstate_n     = IDLE;
              end
            end else begin
              wr_ptr_n = commit_ptr;
              drop_inc = 2'd1;
              wstate_n = in_bus.tlast ? IDLE : DROP;
            end
          end
          DROP:    if (in_bus.tlast) wstate_n = IDLE;
          default: ;
        endcase
      end
    end
  end

  // The commit is seen by the read side one cycle late, so a read never targets the beat being written.
  assign pkt_dec        = out_valid && rbeat.tlast;
  assign pkt_count_next = pkt_count + ptr_t'(pkt_inc_q) - ptr_t'(pkt_dec);
  assign rd_en          = out_bus.tready && (pkt_count_next != '0);
  assign drop_sum       = {1'b0, drop_count} + {{(DROP_CNT_W-1){1'b0}}, drop_inc};

  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      wstate     <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_count  <= '0;
      pkt_inc_q  <= 1'b0;
      out_valid  <= 1'b0;
      drop_count <= '0;
    end else begin
      wstate     <= wstate_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      pkt_count  <= pkt_count_next;
      pkt_inc_q  <= pkt_inc;
      out_valid  <= rd_en;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
      drop_count <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_pcie) begin
    if (!rst && rd_en) assert (rd_ptr != commit_ptr);
  end

  pcileech_ram_sdp_1clk #(.AW(DEPTH_LOG2), .DW(BEAT_W)) ram (
    .clk   (clk_pcie),
    .we    (we),
    .waddr (waddr[DEPTH_LOG2-1:0]),
    .wdata (wbeat),
    .re    (rd_en),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (rbeat)
  );

  assign out_bus.tdata    = rbeat.tdata;
  assign out_bus.tkeepdw  = rbeat.tkeepdw;
  assign out_bus.tlast    = rbeat.tlast;
  assign out_bus.tuser    = {8'b0, rbeat.first};
  assign out_bus.tvalid   = out_valid;
  assign out_bus.has_data = (pkt_count_next != '0);
  assign in_bus.tready    = 1'b1;
  assign level            = wr_ptr - rd_ptr;
  assign unused_bits      = ^{in_bus.tuser[8:1], in_bus.has_data, waddr[PW-1]};
endmodule

// File: tb/tb_pcileech_tlps128_pkt_buffer.sv
// Directed bench for the TLP packet buffer: vector table for fill/drop levels plus hand-timed sequences.
module tb_pcileech_tlps128_pkt_buffer;
  import pcileech_tlps128_pkt_buffer_pkg::*;

  localparam int DL = 3;
  localparam int CW = 4;
  localparam int BW = 134;

  logic clk_pcie = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] drop_count;
  logic [DL:0] level;
  wstate_t wstate;

  pcileech_tlps128_pkt_buffer_if in_bus();
  pcileech_tlps128_pkt_buffer_if out_bus();

  pcileech_tlps128_pkt_buffer #(.DEPTH_LOG2(DL), .DROP_CNT_W(CW)) dut (
    .clk_pcie   (clk_pcie),
    .rst        (rst),
    .in_bus     (in_bus),
    .out_bus    (out_bus),
    .drop_count (drop_count),
    .level      (level),
    .wstate     (wstate)
  );

  // clock / watchdog
  always #5 clk_pcie = ~clk_pcie;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // scoreboard
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] exp_beat;
  int n_checks = 0;
  int n_fail = 0;
  int n_out = 0;
  logic prev_tready = 1'b0;

  task automatic check(input string name, input logic [141:0] act, input logic [141:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_pcie) begin
    if (out_bus.tvalid === 1'b1) begin
      n_out++;
      check("tvalid_after_tready", {141'b0, prev_tready}, 142'd1);
      check("beat_expected", {141'b0, exp_q.size() != 0}, 142'd1);
      if (exp_q.size() != 0) begin
        exp_beat = exp_q.pop_front();
        check("out_beat", {out_bus.tuser, out_bus.tlast, out_bus.tkeepdw, out_bus.tdata},
              {8'b0, exp_beat});
      end
    end
    prev_tready = out_bus.tready;
  end

  // driver tasks
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic put_beat(input logic first, input logic last, input logic [3:0] keep,
                          input logic [127:0] data, input bit push);
    in_bus.tvalid  = 1'b1;
    in_bus.tuser   = {8'hA5, first};
    in_bus.tlast   = last;
    in_bus.tkeepdw = keep;
    in_bus.tdata   = data;
    if (push) exp_q.push_back({first, last, keep, data});
  endtask

  task automatic next_cycle();
    @(posedge clk_pcie);
    #1;
  endtask

  task automatic send_pkt(input int len, input logic [3:0] last_keep, input bit push);
    for (int b = 0; b < len; b++) begin
      put_beat(b == 0, b == len - 1, (b == len - 1) ? last_keep : 4'hF, rand128(), push);
      next_cycle();
    end
    in_bus.tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    out_bus.tready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      next_cycle();
      n++;
    end
    repeat (3) next_cycle();
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk_pcie);
    check({tag, "_tvalid"}, out_bus.tvalid, 0);
    check({tag, "_has_data"}, out_bus.has_data, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_drop"}, drop_count, 0);
    check({tag, "_wstate"}, wstate, IDLE);
    next_cycle();
  endtask

  typedef struct {
    int         len;
    logic [3:0] last_keep;
    bit         stored;
    int         exp_level;
    int         exp_drop;
  } vec_t;
  vec_t vecs[5];

  initial begin
    vecs[0] = '{6, 4'h7, 1'b1, 6, 0};
    vecs[1] = '{4, 4'h1, 1'b0, 6, 1};
    vecs[2] = '{2, 4'h3, 1'b1, 8, 1};
    vecs[3] = '{1, 4'hF, 1'b0, 8, 2};
    vecs[4] = '{3, 4'h1, 1'b0, 8, 3};

    in_bus.tvalid = 1'b0;
    in_bus.tuser = '0;
    in_bus.tlast = 1'b0;
    in_bus.tkeepdw = '0;
    in_bus.tdata = '0;
    in_bus.has_data = 1'b0;
    out_bus.tready = 1'b0;
    next_cycle();
    do_reset();
    check_reset_state("reset");

    // 3-beat TLP with tready held high: exact cycle timing of has_data and output beats
    out_bus.tready = 1'b1;
    put_beat(1'b1, 1'b0, 4'hF, rand128(), 1'b1);
    @(negedge clk_pcie); check("t1_has_data_b0", out_bus.has_data, 0); next_cycle();
    put_beat(1'b0, 1'b0, 4'hF, rand128(), 1'b1);
    @(negedge clk_pcie); check("t1_has_data_b1", out_bus.has_data, 0); next_cycle();
    put_beat(1'b0, 1'b1, 4'h3, rand128(), 1'b1);
    @(negedge clk_pcie); check("t1_has_data_at_tlast", out_bus.has_data, 0); next_cycle();
    in_bus.tvalid = 1'b0;
    @(negedge clk_pcie);
    check("t1_has_data_rise", out_bus.has_data, 1);
    check("t1_tvalid_before", out_bus.tvalid, 0);
    @(negedge clk_pcie);
    check("t1_tvalid_b0", out_bus.tvalid, 1);
    check("t1_tlast_b0", out_bus.tlast, 0);
    @(negedge clk_pcie);
    check("t1_tvalid_b1", out_bus.tvalid, 1);
    check("t1_tlast_b1", out_bus.tlast, 0);
    @(negedge clk_pcie);
    check("t1_tvalid_b2", out_bus.tvalid, 1);
    check("t1_tlast_b2", out_bus.tlast, 1);
    check("t1_has_data_fall", out_bus.has_data, 0);
    @(negedge clk_pcie);
    check("t1_tvalid_after", out_bus.tvalid, 0);
    next_cycle();
    drain("t1_drain", 10);

    // two 1-beat TLPs back-to-back while tready toggles
    out_bus.tready = 1'b0;
    n_out = 0;
    fork
      begin
        send_pkt(1, 4'h1, 1'b1);
        send_pkt(1, 4'h3, 1'b1);
      end
      begin
        for (int i = 0; i < 12; i++) begin
          out_bus.tready = ~out_bus.tready;
          next_cycle();
        end
      end
    join
    out_bus.tready = 1'b0;
    repeat (3) next_cycle();
    check("t2_beats_out", n_out, 2);
    check("t2_queue_empty", exp_q.size(), 0);

    // commit of the next packet coincides with the tlast of the packet being read
    out_bus.tready = 1'b1;
    send_pkt(2, 4'hF, 1'b1);
    send_pkt(2, 4'h1, 1'b1);
    @(negedge clk_pcie);
    check("t6_tlast_a", out_bus.tlast & out_bus.tvalid, 1);
    check("t6_has_data_kept", out_bus.has_data, 1);
    @(negedge clk_pcie);
    check("t6_tvalid_b0", out_bus.tvalid, 1);
    @(negedge clk_pcie);
    check("t6_tlast_b", out_bus.tlast & out_bus.tvalid, 1);
    check("t6_has_data_fall", out_bus.has_data, 0);
    next_cycle();
    drain("t6_drain", 10);

    // orphan beat ignored, then a packet that loses its tlast is rewound
    out_bus.tready = 1'b0;
    put_beat(1'b0, 1'b1, 4'hF, rand128(), 1'b0);
    next_cycle();
    in_bus.tvalid = 1'b0;
    @(negedge clk_pcie);
    check("t4_orphan_level", level, 0);
    check("t4_orphan_wstate", wstate, IDLE);
    next_cycle();
    put_beat(1'b1, 1'b0, 4'hF, rand128(), 1'b0);
    next_cycle();
    put_beat(1'b0, 1'b0, 4'hF, rand128(), 1'b0);
    next_cycle();
    send_pkt(3, 4'h3, 1'b1);
    @(negedge clk_pcie);
    check("t4_drop", drop_count, 1);
    check("t4_level", level, 3);
    next_cycle();
    drain("t4_drain", 20);

    // fill/overflow table with the output stalled
    do_reset();
    check_reset_state("reset2");
    out_bus.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_pkt(vecs[i].len, vecs[i].last_keep, vecs[i].stored);
      @(negedge clk_pcie);
      check("tbl_level", level, vecs[i].exp_level);
      check("tbl_drop", drop_count, vecs[i].exp_drop);
      check("tbl_wstate", wstate, IDLE);
      next_cycle();
    end
    drain("tbl_drain", 40);
    @(negedge clk_pcie); check("tbl_level_empty", level, 0); next_cycle();

    // oversize packet always drops; exactly-full packet is kept
    out_bus.tready = 1'b0;
    send_pkt(9, 4'hF, 1'b0);
    @(negedge clk_pcie);
    check("oversize_level", level, 0);
    check("oversize_drop", drop_count, 4);
    next_cycle();
    send_pkt(8, 4'h3, 1'b1);
    @(negedge clk_pcie); check("fit_level", level, 8); next_cycle();

    // drop counter saturation while the buffer is full
    for (int i = 0; i < 11; i++) send_pkt(1, 4'hF, 1'b0);
    @(negedge clk_pcie); check("sat_reach_max", drop_count, 15); next_cycle();
    send_pkt(3, 4'h7, 1'b0);
    @(negedge clk_pcie);
    check("sat_hold", drop_count, 15);
    check("sat_level", level, 8);
    next_cycle();
    drain("fit_drain", 40);

    // reset in the middle of emitting a 4-beat TLP
    out_bus.tready = 1'b0;
    send_pkt(4, 4'h7, 1'b1);
    out_bus.tready = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk_pcie);
    check("t5_tvalid", out_bus.tvalid, 0);
    check("t5_has_data", out_bus.has_data, 0);
    check("t5_level", level, 0);
    check("t5_drop", drop_count, 0);
    next_cycle();
    send_pkt(2, 4'h7, 1'b1);
    drain("t5_after_drain", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
